perf_counter_reader: RTL and testbench

Read-side companion to the team's dual 64-bit event counter: on request, it atomically snapshots both counter values and streams them out as 32-bit words over a valid/ready handshake. It can optionally issue a one-cycle clear pulse back to the counter. It sits between the counter pair and the CPU's memory-mapped peripheral read path (or a debug UART serializer), so software sees a coherent pair of counts.

---
 rtl/perf_counter_reader_pkg.sv | 24 ++
 rtl/perf_counter_reader.sv | 124 ++++++++++++
 tb/tb_perf_counter_reader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/perf_counter_reader_pkg.sv
// Shared types and sizing helpers for the perf counter readout block.
package perf_counter_reader_pkg;

   localparam int unsigned DEF_WORD_W = 32;
   localparam int unsigned DEF_CNT_W  = 64;

   // Readout controller states
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // Number of output words needed to carry one counter
   function automatic int unsigned words_per_cnt(input int unsigned cnt_w,
                                                 input int unsigned word_w);
      return cnt_w / word_w;
   endfunction

   // Width of the word index register, never narrower than one bit
   function automatic int unsigned idx_width(input int unsigned total_words);
      return (total_words > 1) ? $clog2(total_words) : 1;
   endfunction

endpackage

// File: rtl/perf_counter_reader.sv
// Atomic snapshot of two event counters, streamed out LS word first over valid/ready.
module perf_counter_reader
   import perf_counter_reader_pkg::*;
#(
   parameter int unsigned CNT_W  = DEF_CNT_W,
   parameter int unsigned WORD_W = DEF_WORD_W
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Req,
   input  logic              ClrOnRead,
   input  logic [CNT_W-1:0]  Count0,
   input  logic [CNT_W-1:0]  Count1,
   input  logic              Ready,
   output logic [WORD_W-1:0] Data,
   output logic              Valid,
   output logic              Last,
   output logic              Busy,
   output logic              ClrCnt,
   output logic              Done
);

   localparam int unsigned      NW       = words_per_cnt(CNT_W, WORD_W);
   localparam int unsigned      TOTAL    = 2 * NW;
   localparam int unsigned      IDX_W    = idx_width(TOTAL);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

   state_t             state_q;
   state_t             state_d;
   logic [IDX_W-1:0]   idx_q;
   logic [IDX_W-1:0]   idx_d;
   logic               clr_q;
   logic               clr_d;
   logic               done_q;
   logic               done_d;
   logic               capture;
   logic               send;
   logic [CNT_W-1:0]   snap0_q;
   logic [CNT_W-1:0]   snap1_q;
   logic [2*CNT_W-1:0] snap_all;
   logic [WORD_W-1:0]  words [TOTAL];

   // Next-state, index and pulse decode; Req is only looked at in IDLE
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      clr_d   = 1'b0;
      done_d  = 1'b0;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (Req) begin
               state_d = ST_SEND;
               idx_d   = '0;
               capture = 1'b1;
               clr_d   = ClrOnRead;
            end
         end
         ST_SEND: begin
            if (Ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Control registers; reset aborts a readout with no Done or clear pulse
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         clr_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         clr_q   <= clr_d;
         done_q  <= done_d;
      end
   end

   // Both counters captured on the same edge so software sees a coherent pair
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         snap0_q <= '0;
         snap1_q <= '0;
      end else if (capture) begin
         snap0_q <= Count0;
         snap1_q <= Count1;
      end
   end

   assign snap_all = {snap1_q, snap0_q};

   // Word k is counter k/NW, slice k%NW, which is simply slice k of the concatenation
   always_comb begin
      for (int k = 0; k < TOTAL; k++) begin
         words[k] = snap_all[k*WORD_W +: WORD_W];
      end
   end

   assign send = (state_q == ST_SEND);

   // Outputs decoded from registered state only
   always_comb begin
      Valid  = send;
      Busy   = send;
      Last   = send && (idx_q == LAST_IDX);
      Data   = send ? words[idx_q] : '0;
      ClrCnt = clr_q;
      Done   = done_q;
   end

endmodule

// File: tb/tb_perf_counter_reader.sv
// Self-checking bench for perf_counter_reader against a word-list reference model.
module tb_perf_counter_reader;

   localparam int unsigned CNT_W  = 64;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned NW     = CNT_W / WORD_W;
   localparam int unsigned TOTAL  = 2 * NW;

   logic              Clk;
   logic              Reset;
   logic              Req;
   logic              ClrOnRead;
   logic [CNT_W-1:0]  Count0;
   logic [CNT_W-1:0]  Count1;
   logic              Ready;
   logic [WORD_W-1:0] Data;
   logic              Valid;
   logic              Last;
   logic              Busy;
   logic              ClrCnt;
   logic              Done;

   int n_run;
   int n_fail;

   perf_counter_reader #(.CNT_W(CNT_W), .WORD_W(WORD_W)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Req       (Req),
      .ClrOnRead (ClrOnRead),
      .Count0    (Count0),
      .Count1    (Count1),
      .Ready     (Ready),
      .Data      (Data),
      .Valid     (Valid),
      .Last      (Last),
      .Busy      (Busy),
      .ClrCnt    (ClrCnt),
      .Done      (Done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [CNT_W-1:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   // Reference: the ordered list of words a snapshot of (c0, c1) must produce
   function automatic logic [WORD_W-1:0] model_word(input logic [CNT_W-1:0] c0,
                                                     input logic [CNT_W-1:0] c1,
                                                     input int k);
      logic [CNT_W-1:0] src;
      src = (k < int'(NW)) ? c0 : c1;
      return WORD_W'(src >> ((k % int'(NW)) * int'(WORD_W)));
   endfunction

   // One full readout. mode: 0 Ready=1, 1 random, 2 stall word 1 for 3 cycles, 3 Ready low 2 cycles
   task automatic do_readout(input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] c1,
                             input logic clr, input int mode, input bit mutate,
                             input bit poke, input string tag);
      logic [WORD_W-1:0] exp_q[$];
      logic [4:0]        exp_f;
      logic              rdy;
      int                cyc;
      int                stall;
      int                widx;
      for (int k = 0; k < int'(TOTAL); k++) exp_q.push_back(model_word(c0, c1, k));
      Count0    = c0;
      Count1    = c1;
      ClrOnRead = clr;
      Req       = 1'b1;
      Ready     = (mode == 0) ? 1'b1 : ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      @(posedge Clk);
      #1;
      Req       = 1'b0;
      ClrOnRead = 1'($urandom_range(0, 1));
      cyc = 0; stall = 0; widx = 0;
      while (exp_q.size() > 0 && cyc < 200) begin
         cyc++;
         // {Valid, Last, Busy, ClrCnt, Done}
         exp_f = {1'b1, exp_q.size() == 1, 1'b1, clr && (cyc == 1), 1'b0};
         n_run++;
         if ({Valid, Last, Busy, ClrCnt, Done} !== exp_f) begin
            n_fail++;
            $display("FAIL %s flags cyc=%0d word=%0d got=%b want=%b", tag, cyc, widx,
                     {Valid, Last, Busy, ClrCnt, Done}, exp_f);
         end
         n_run++;
         if (Data !== exp_q[0]) begin
            n_fail++;
            $display("FAIL %s data cyc=%0d word=%0d got=%h want=%h", tag, cyc, widx, Data, exp_q[0]);
         end
         case (mode)
            0: rdy = 1'b1;
            1: rdy = 1'($urandom_range(0, 1));
            2: begin
               if (widx == 1 && stall < 3) begin
                  rdy = 1'b0;
                  stall++;
               end else begin
                  rdy = 1'b1;
               end
            end
            default: rdy = (cyc > 2);
         endcase
         Ready = rdy;
         if (poke) Req = (widx == 1);
         if (mutate) begin
            Count0 = rnd64();
            Count1 = rnd64();
         end
         @(posedge Clk);
         #1;
         Req = 1'b0;
         if (rdy) begin
            void'(exp_q.pop_front());
            widx++;
         end
      end
      n_run++;
      if (cyc >= 200) begin
         n_fail++;
         $display("FAIL %s timeout words_left=%0d want=0", tag, exp_q.size());
      end
      // Cycle after the final accept: Done high, back in IDLE
      n_run++;
      if ({Valid, Last, Busy, ClrCnt, Done, Data} !== {5'b00001, {WORD_W{1'b0}}}) begin
         n_fail++;
         $display("FAIL %s done_cycle got=%b data=%h want=00001 data=0", tag,
                  {Valid, Last, Busy, ClrCnt, Done}, Data);
      end
      Ready = 1'b0;
      @(posedge Clk);
      #1;
      n_run++;
      if ({Valid, Busy, Done} !== 3'b000) begin
         n_fail++;
         $display("FAIL %s idle_after got=%b want=000", tag, {Valid, Busy, Done});
      end
   endtask

   task automatic test_reset();
      Reset = 1'b0; Req = 1'b1; ClrOnRead = 1'b1; Ready = 1'b1;
      Count0 = rnd64(); Count1 = rnd64();
      repeat (2) @(posedge Clk);
      #1;
      n_run++;
      if ({Valid, Last, Busy, ClrCnt, Done, Data} !== '0) begin
         n_fail++;
         $display("FAIL reset got=%b data=%h want=00000 data=0", {Valid, Last, Busy, ClrCnt, Done}, Data);
      end
      Req = 1'b0; ClrOnRead = 1'b0; Ready = 1'b0;
      Reset = 1'b1;
      @(posedge Clk);
      #1;
   endtask

   task automatic test_basic();
      do_readout(64'h0000_0001_0000_0002, 64'h0000_0000_0000_0007, 1'b0, 0, 1'b0, 1'b0, "basic");
   endtask

   task automatic test_atomicity();
      do_readout(rnd64(), rnd64(), 1'b0, 0, 1'b1, 1'b0, "atomic");
   endtask

   task automatic test_backpressure();
      do_readout(rnd64(), rnd64(), 1'b0, 2, 1'b1, 1'b0, "backpressure");
   endtask

   task automatic test_clear_on_read();
      do_readout(rnd64(), rnd64(), 1'b1, 3, 1'b0, 1'b0, "clear_on_read");
   endtask

   task automatic test_req_while_busy();
      do_readout(rnd64(), rnd64(), 1'b0, 0, 1'b0, 1'b1, "req_busy");
   endtask

   // Req and Ready held high: a new readout starts every TOTAL+1 cycles
   task automatic test_back_to_back();
      logic [CNT_W-1:0]  c0;
      logic [CNT_W-1:0]  c1;
      logic [WORD_W-1:0] exp_d;
      logic [1:0]        exp_f;
      int                ph;
      c0 = rnd64(); c1 = rnd64();
      Count0 = c0; Count1 = c1; ClrOnRead = 1'b0;
      Req = 1'b1; Ready = 1'b1;
      @(posedge Clk);
      for (int c = 1; c <= 14; c++) begin
         #1;
         ph    = c % int'(TOTAL + 1);
         exp_f = {ph != 0, ph == 0};
         exp_d = (ph != 0) ? model_word(c0, c1, ph - 1) : '0;
         n_run++;
         if ({Valid, Done} !== exp_f || Data !== exp_d) begin
            n_fail++;
            $display("FAIL b2b cyc=%0d valid_done=%b data=%h want=%b data=%h", c,
                     {Valid, Done}, Data, exp_f, exp_d);
         end
         @(posedge Clk);
      end
      #1;
      Req = 1'b0;
      repeat (8) @(posedge Clk);
      #1;
      Ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      Count0 = rnd64(); Count1 = rnd64(); ClrOnRead = 1'b1;
      Req = 1'b1; Ready = 1'b1;
      @(posedge Clk);
      #1;
      Req = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b0;
      #1;
      n_run++;
      if ({Valid, Last, Busy, ClrCnt, Done, Data} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid got=%b data=%h want=00000 data=0", {Valid, Last, Busy, ClrCnt, Done}, Data);
      end
      repeat (2) @(posedge Clk);
      #1;
      n_run++;
      if ({Valid, Busy, ClrCnt, Done} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_mid_hold got=%b want=0000", {Valid, Busy, ClrCnt, Done});
      end
      Reset = 1'b1;
      Ready = 1'b0;
      @(posedge Clk);
      #1;
      do_readout(rnd64(), rnd64(), 1'b0, 0, 1'b0, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++) begin
         do_readout(rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1, 1'b1, 1'($urandom_range(0, 1)), "random");
      end
   endtask

   initial begin
      n_run  = 0;
      n_fail = 0;
      test_reset();
      test_basic();
      test_atomicity();
      test_backpressure();
      test_clear_on_read();
      test_req_while_busy();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
